// File: rtl/enc_stage_2_parity_buffer.sv
// Second encoder stage: inserts the overall even-parity bit into the stage-1
// word for the selected code, then holds finished codewords in a two-entry
// in-order buffer with a valid/ready handshake toward the readout side.
// A free-running count of delivered codewords is kept alongside.
module enc_stage_2_parity_buffer #(
  parameter int AMBA_WORD          = 32,
  parameter int MAX_CODEWORD_WIDTH = 32,
  parameter int COUNT_WIDTH        = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [MAX_CODEWORD_WIDTH-1:0] s1_word,
  input  logic                          s1_valid,
  input  logic [AMBA_WORD-1:0]          work_mod,
  output logic                          s1_ready,
  output logic [MAX_CODEWORD_WIDTH-1:0] data_out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          mode_err,
  input  logic                          count_clr,
  output logic [COUNT_WIDTH-1:0]        enc_count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_t;

  logic                          mode_legal;
  logic [6:0]                    width_sel;
  logic [6:0]                    pslot_sel;
  logic [MAX_CODEWORD_WIDTH-1:0] keep_mask;
  logic [MAX_CODEWORD_WIDTH-1:0] pslot_hot;
  logic [MAX_CODEWORD_WIDTH-1:0] masked_word;
  logic                          parity_bit;
  logic [MAX_CODEWORD_WIDTH-1:0] codeword;

  buf_state_t                    state_reg;
  logic [MAX_CODEWORD_WIDTH-1:0] head_reg;
  logic [MAX_CODEWORD_WIDTH-1:0] tail_reg;
  logic                          out_valid_reg;
  logic                          s1_ready_reg;
  logic                          mode_err_reg;
  logic [COUNT_WIDTH-1:0]        count_reg;

  logic                          push;
  logic                          pop;

  // Decode codeword width and parity-slot position from the mode field
  always_comb begin
    mode_legal = 1'b0;
    width_sel  = 7'd0;
    pslot_sel  = 7'd0;
    case (work_mod)
      AMBA_WORD'(0): begin mode_legal = 1'b1; width_sel = 7'd8;  pslot_sel = 7'd3; end
      AMBA_WORD'(1): begin mode_legal = 1'b1; width_sel = 7'd16; pslot_sel = 7'd4; end
      AMBA_WORD'(2): begin mode_legal = 1'b1; width_sel = 7'd32; pslot_sel = 7'd5; end
      default:       begin mode_legal = 1'b0; width_sel = 7'd0;  pslot_sel = 7'd0; end
    endcase
  end

  // Per-bit masks: keep info/Hamming bits below W except the parity slot.
  // An illegal mode clears every mask so the codeword collapses to zero.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_CODEWORD_WIDTH; gi++) begin : g_bit
      localparam logic [6:0] BIT_IDX = 7'(gi);
      assign keep_mask[gi] = mode_legal && (BIT_IDX < width_sel) && (BIT_IDX != pslot_sel);
      assign pslot_hot[gi] = mode_legal && (BIT_IDX == pslot_sel);
    end
  endgenerate

  assign masked_word = s1_word & keep_mask;
  assign parity_bit  = ^masked_word;
  assign codeword    = masked_word | (pslot_hot & {MAX_CODEWORD_WIDTH{parity_bit}});

  assign push = s1_valid & s1_ready_reg;
  assign pop  = out_valid_reg & out_ready;

  // Buffer FSM; head_reg is always the oldest word and is zero when empty
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_EMPTY;
      head_reg      <= '0;
      tail_reg      <= '0;
      out_valid_reg <= 1'b0;
      s1_ready_reg  <= 1'b1;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (push) begin
            head_reg      <= codeword;
            state_reg     <= ST_ONE;
            out_valid_reg <= 1'b1;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            head_reg <= codeword;
          end else if (push) begin
            tail_reg     <= codeword;
            state_reg    <= ST_FULL;
            s1_ready_reg <= 1'b0;
          end else if (pop) begin
            head_reg      <= '0;
            state_reg     <= ST_EMPTY;
            out_valid_reg <= 1'b0;
          end
        end
        ST_FULL: begin
          if (pop) begin
            head_reg     <= tail_reg;
            tail_reg     <= '0;
            state_reg    <= ST_ONE;
            s1_ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg     <= ST_EMPTY;
          head_reg      <= '0;
          tail_reg      <= '0;
          out_valid_reg <= 1'b0;
          s1_ready_reg  <= 1'b1;
        end
      endcase
    end
  end

  // Sticky flag for any accepted word carrying an illegal mode
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_err_reg <= 1'b0;
    end else if (push && !mode_legal) begin
      mode_err_reg <= 1'b1;
    end
  end

  // Delivered-codeword counter; clear wins over a simultaneous pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (count_clr) begin
      count_reg <= '0;
    end else if (pop) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign s1_ready  = s1_ready_reg;
  assign out_valid = out_valid_reg;
  assign data_out  = head_reg;
  assign mode_err  = mode_err_reg;
  assign enc_count = count_reg;

endmodule
